// File: rtl/bht_counter_table.sv
// Branch-history table of saturating prediction counters.
// Owns counter read-modify-write on update, write-first bypass to the
// predict port, and a one-entry-per-cycle initialisation sweep after reset
// or flush.
//
// Handshake: a request (pred_valid or upd_valid) is accepted on a rising
// edge only when ready=1 and flush=0 in that cycle; otherwise it is
// silently dropped. An accepted lookup returns pred_ctr/pred_taken with
// pred_out_valid=1 exactly one cycle later; there is no back-pressure on
// the result.
module bht_counter_table #(
    parameter int CTR_WIDTH   = 2,
    parameter int INDEX_WIDTH = 8,
    parameter int INIT_VALUE  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   pred_valid,
    input  logic [INDEX_WIDTH-1:0] pred_index,
    input  logic                   upd_valid,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  logic                   upd_taken,
    output logic                   ready,
    output logic                   pred_out_valid,
    output logic [CTR_WIDTH-1:0]   pred_ctr,
    output logic                   pred_taken,
    output logic                   init_busy
);

    localparam int                     DEPTH    = 2 ** INDEX_WIDTH;
    localparam logic [CTR_WIDTH-1:0]   CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0]   INIT_CTR = CTR_WIDTH'(INIT_VALUE);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] init_ptr;
    logic [CTR_WIDTH-1:0]   mem [DEPTH];

    logic                   upd_fire;
    logic                   pred_fire;
    logic [CTR_WIDTH-1:0]   upd_old;
    logic [CTR_WIDTH-1:0]   upd_new;
    logic [CTR_WIDTH-1:0]   pred_rd;

    // A flush in READY cancels everything else issued in the same cycle.
    assign upd_fire  = (state == ST_READY) && upd_valid  && !flush;
    assign pred_fire = (state == ST_READY) && pred_valid && !flush;

    assign upd_old = mem[upd_index];

    // Saturating increment/decrement of the counter being updated.
    always_comb begin
        upd_new = upd_old;
        if (upd_taken) begin
            if (upd_old != CTR_MAX) upd_new = upd_old + 1'b1;
        end else begin
            if (upd_old != '0) upd_new = upd_old - 1'b1;
        end
    end

    // Write-first read: a same-index update in this cycle is visible to the lookup.
    always_comb begin
        pred_rd = mem[pred_index];
        if (upd_fire && (upd_index == pred_index)) pred_rd = upd_new;
    end

    // Counter storage: sweep writes during INIT, resolved updates during READY.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_ptr] <= INIT_CTR;
        end else if (upd_fire) begin
            mem[upd_index] <= upd_new;
        end
    end

    // Control FSM: sweep pointer, state and registered lookup result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_INIT;
            init_ptr       <= '0;
            pred_out_valid <= 1'b0;
            pred_ctr       <= '0;
        end else begin
            pred_out_valid <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (flush) begin
                        init_ptr <= '0;
                    end else begin
                        init_ptr <= init_ptr + 1'b1;
                        if (init_ptr == LAST_IDX) state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (flush) begin
                        state    <= ST_INIT;
                        init_ptr <= '0;
                    end else if (pred_fire) begin
                        pred_out_valid <= 1'b1;
                        pred_ctr       <= pred_rd;
                    end
                end
                default: begin
                    state    <= ST_INIT;
                    init_ptr <= '0;
                end
            endcase
        end
    end

    assign ready      = (state == ST_READY);
    assign init_busy  = ~ready;
    assign pred_taken = pred_ctr[CTR_WIDTH-1];

endmodule

// File: tb/tb_bht_counter_table.sv
// Bench for bht_counter_table with default parameters (2-bit counters,
// 256 entries, init value 1). Stimulus is driven just after the falling
// edge; outputs are sampled on the falling edge.
module tb_bht_counter_table;

    localparam int DEPTH    = 256;
    localparam int CTR_MAX  = 3;
    localparam int INIT_VAL = 1;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       pred_valid;
    logic [7:0] pred_index;
    logic       upd_valid;
    logic [7:0] upd_index;
    logic       upd_taken;
    logic       ready;
    logic       pred_out_valid;
    logic [1:0] pred_ctr;
    logic       pred_taken;
    logic       init_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bht_counter_table #(
        .CTR_WIDTH  (2),
        .INDEX_WIDTH(8),
        .INIT_VALUE (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .pred_valid    (pred_valid),
        .pred_index    (pred_index),
        .upd_valid     (upd_valid),
        .upd_index     (upd_index),
        .upd_taken     (upd_taken),
        .ready         (ready),
        .pred_out_valid(pred_out_valid),
        .pred_ctr      (pred_ctr),
        .pred_taken    (pred_taken),
        .init_busy     (init_busy)
    );

    // ---------------- scoreboard state ----------------
    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [1:0] exp_q[$];
    int         due_q[$];
    logic       rdy_q[$];

    // Reference model: table contents and sweep progress as plain integers.
    int model[DEPTH];
    bit m_ready;
    int m_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_left  = DEPTH;
        for (int i = 0; i < DEPTH; i++) model[i] = INIT_VAL;
    endtask

    // Advance the model across the coming rising edge for the given inputs.
    task automatic model_step(input bit fl, input bit pv, input int pi,
                              input bit uv, input int ui, input bit ut);
        if (!m_ready) begin
            if (fl) begin
                m_left = DEPTH;
            end else begin
                m_left--;
                if (m_left == 0) m_ready = 1'b1;
            end
        end else if (fl) begin
            model_reset();
        end else begin
            if (uv) begin
                if (ut) model[ui] = (model[ui] >= CTR_MAX) ? CTR_MAX : model[ui] + 1;
                else    model[ui] = (model[ui] <= 0) ? 0 : model[ui] - 1;
            end
            if (pv) begin
                exp_q.push_back(2'(model[pi]));
                due_q.push_back(cyc + 1);
            end
        end
        rdy_q.push_back(m_ready);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input bit fl, input bit pv, input int pi,
                               input bit uv, input int ui, input bit ut);
        @(negedge clk);
        #1;
        flush      = fl;
        pred_valid = pv;
        pred_index = 8'(pi);
        upd_valid  = uv;
        upd_index  = 8'(ui);
        upd_taken  = ut;
        model_step(fl, pv, pi, uv, ui, ut);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic lookup(input int idx);
        drive_cycle(0, 1, idx, 0, 0, 0);
    endtask

    task automatic update(input int idx, input bit tk);
        drive_cycle(0, 0, 0, 1, idx, tk);
    endtask

    task automatic set_idle_inputs();
        flush = 0; pred_valid = 0; pred_index = 0;
        upd_valid = 0; upd_index = 0; upd_taken = 0;
    endtask

    // Assert rst_n mid-cycle, away from any clock edge, and check outputs at once.
    task automatic reset_assert();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        set_idle_inputs();
        #1;
        check("rst_ready",      ready,          0);
        check("rst_init_busy",  init_busy,      1);
        check("rst_pred_valid", pred_out_valid, 0);
        check("rst_pred_ctr",   pred_ctr,       0);
        check("rst_pred_taken", pred_taken,     0);
        exp_q.delete();
        due_q.delete();
        rdy_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_release();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        set_idle_inputs();
        model_reset();
        model_step(0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (rdy_q.size() > 0) begin
                logic er;
                er = rdy_q.pop_front();
                check("ready",     ready,     er);
                check("init_busy", init_busy, !er);
            end
            if (pred_out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pred_out", pred_out_valid, 0);
                end else begin
                    logic [1:0] e;
                    int         d;
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    check("pred_latency", cyc, d);
                    check("pred_ctr",     pred_ctr,   e);
                    check("pred_taken",   pred_taken, e[1]);
                end
            end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
                check("missing_pred_out", pred_out_valid, 1);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        set_idle_inputs();
        #3;
        check("por_ready",      ready,          0);
        check("por_init_busy",  init_busy,      1);
        check("por_pred_valid", pred_out_valid, 0);
        check("por_pred_ctr",   pred_ctr,       0);
        repeat (2) @(negedge clk);

        // Initial sweep, then defaults at the edges of the table.
        reset_release();
        idle(DEPTH + 2);
        lookup(0); lookup(128); lookup(255);
        idle(2);

        // Saturation up and down on one entry.
        update(5, 1); update(5, 1); update(5, 1);
        lookup(5);
        for (int i = 0; i < 5; i++) update(5, 0);
        lookup(5);
        idle(2);

        // Same-cycle lookup and update: same index (bypass) and different index.
        drive_cycle(0, 1, 9, 1, 9, 1);
        drive_cycle(0, 1, 10, 1, 9, 1);
        lookup(9);
        idle(2);

        // Flush drops the update issued with it; requests during the sweep are ignored.
        update(7, 1); update(7, 1);
        lookup(7);
        drive_cycle(1, 1, 7, 1, 8, 1);
        for (int i = 0; i < 40; i++)
            drive_cycle(0, 1, $urandom_range(0, 15), 1, $urandom_range(0, 15), 1);
        idle(DEPTH - 40 + 2);
        lookup(7); lookup(8);
        for (int i = 0; i < 16; i++) lookup(i);
        idle(2);

        // Randomised traffic over a narrow index window so collisions are common.
        for (int i = 0; i < 2000; i++) begin
            bit fl;
            int pi;
            int ui;
            fl = ($urandom_range(0, 699) == 0);
            pi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
            ui = ($urandom_range(0, 3) == 0) ? pi : $urandom_range(0, 7);
            drive_cycle(fl, $urandom_range(0, 1), pi, $urandom_range(0, 1), ui,
                        $urandom_range(0, 1));
        end
        idle(DEPTH + 2);
        for (int i = 0; i < 8; i++) lookup(i);
        idle(2);

        // Reset in the middle of a sweep restarts it from entry 0.
        reset_assert();
        reset_release();
        idle(99);
        reset_assert();
        reset_release();
        idle(DEPTH + 2);

        // Reset in the middle of operation clears a non-zero result register.
        update(20, 1); update(20, 1);
        lookup(20);
        idle(2);
        reset_assert();
        reset_release();
        idle(DEPTH + 2);
        lookup(20);
        idle(3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bht_counter_table.md
Name: bht_counter_table

Overview:
Parametrised branch-history table of saturating prediction counters. It is the next generation of the 2-bit predictor table storage block. The table now owns counter arithmetic (read-modify-write update), write-first bypass to the predict port, and a hardware initialisation sweep after reset or flush. It sits between fetch, which issues predict lookups, and the branch resolution unit, which issues updates.

Parameters:
CTR_WIDTH, 2, counter width in bits; taken prediction = counter MSB
INDEX_WIDTH, 8, table index width; DEPTH = 2**INDEX_WIDTH entries
INIT_VALUE, 1, value written to every entry by the init sweep (weakly not-taken for CTR_WIDTH=2); must be < 2**CTR_WIDTH

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  single-cycle request to re-initialise the whole table
pred_valid  input  1  lookup request this cycle
pred_index  input  INDEX_WIDTH  lookup index
upd_valid  input  1  update request this cycle
upd_index  input  INDEX_WIDTH  update index
upd_taken  input  1  resolved direction: 1 = increment, 0 = decrement
ready  output  1  table accepts pred/upd requests
pred_out_valid  output  1  lookup result valid (one cycle after an accepted pred_valid)
pred_ctr  output  CTR_WIDTH  counter value for the lookup
pred_taken  output  1  pred_ctr MSB
init_busy  output  1  init sweep in progress (equals ~ready)

Behaviour:
- Storage: DEPTH x CTR_WIDTH flop array. The array is not reset; contents are defined only by the init sweep.
- FSM states: INIT and READY.
- Reset (async, rst_n=0):
  - state=INIT, init_ptr=0
  - ready=0, init_busy=1, pred_out_valid=0, pred_ctr=0, pred_taken=0
  - Holds regardless of clk.
- INIT:
  - Each cycle: mem[init_ptr] <= INIT_VALUE, init_ptr++.
  - On the cycle writing entry DEPTH-1: next state READY, init_ptr wraps to 0.
  - After rst_n deasserts, ready rises exactly DEPTH cycles later.
  - pred_valid and upd_valid are ignored; pred_out_valid=0.
- READY:
  - ready=1.
  - Accepted update (upd_valid=1): mem[upd_index] <= upd_taken ? min(ctr+1, 2**CTR_WIDTH-1) : max(ctr-1, 0). Saturates, never wraps. Takes effect in 1 cycle, so back-to-back updates to the same index accumulate correctly.
  - Accepted lookup (pred_valid=1): at the same edge, pred_ctr <= mem[pred_index], pred_out_valid <= 1.
  - Otherwise pred_out_valid <= 0, and pred_ctr/pred_taken hold their last value.
  - Lookup latency: 1 cycle.
- Same-cycle lookup and update to the same index: write-first. pred_ctr returns the post-update (saturated) value.
- Same-cycle lookup and update to different indices: independent.
- flush=1:
  - In READY: next state INIT, init_ptr=0. Any upd_valid in that same cycle is dropped. pred_out_valid=0 next cycle.
  - In INIT: restarts the sweep at init_ptr=0.
- Reset mid-sweep or mid-operation: immediate return to the reset state; the sweep restarts from 0 after rst_n deasserts.
- pred_taken is always pred_ctr[CTR_WIDTH-1]. With CTR_WIDTH=1, the counter acts as a last-direction bit.

Test Plan:
- Reset release (defaults) -> ready=0 for exactly 256 cycles, then 1. Lookups of idx 0, 128, 255 -> pred_ctr=1, pred_taken=0, pred_out_valid high 1 cycle after each request.
- Updates to idx 5: taken x3 on consecutive cycles -> lookup gives 3, taken=1. Then not-taken x5 -> lookup gives 0 (saturated, no wrap to 3).
- Same cycle: upd idx 9 taken + pred idx 9 -> next cycle pred_ctr=2, pred_taken=1. Same cycle: upd idx 9 taken + pred idx 10 -> pred_ctr=1.
- Write idx 7 to 3, then flush with upd_valid=1 on idx 8 in the same cycle -> ready low 256 cycles. Afterwards idx 7=1 and idx 8=1 (update dropped).
- pred_valid/upd_valid asserted during the sweep -> pred_out_valid stays 0. After ready, the targeted entries still read INIT_VALUE.
- rst_n pulsed low with init_ptr=100 -> outputs zero asynchronously. After release, ready rises 256 cycles later, not 156.
